// File: rtl/router_fsm_ctrl_n.sv
// Packet-write controller for a 1xN router: header decode, load sequencing, full stalls.
// Optional WAIT_TILL_EMPTY timeout is built when ROUTER_WAIT_TIMEOUT_EN is defined.
module router_fsm_ctrl_n #(
  parameter int NUM_PORTS      = 3,
  parameter int ADDR_W         = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    din,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] soft_rst,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic [ADDR_W-1:0]    dest_sel,
  output logic                 detect_addr,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 wr_en_req,
  output logic                 busy,
  output logic                 drop_pkt,
  output logic                 timeout_err
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  localparam int SEL_N = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NP_W = (ADDR_W+1)'(NUM_PORTS);

  state_t state, next;

  logic [SEL_N-1:0] empty_x, full_x, srst_x;
  logic din_ok, e, f, sr, e_din, tmo;

  // Zero-extend per-port vectors so any address indexes safely.
  always_comb begin
    empty_x = '0;
    full_x  = '0;
    srst_x  = '0;
    empty_x[NUM_PORTS-1:0] = fifo_empty;
    full_x[NUM_PORTS-1:0]  = fifo_full;
    srst_x[NUM_PORTS-1:0]  = soft_rst;
  end

  assign din_ok = ({1'b0, din} < NP_W);
  assign e_din  = empty_x[din];
  assign e      = empty_x[dest_sel];
  assign f      = full_x[dest_sel];
  assign sr     = srst_x[dest_sel];

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != WAIT_TILL_EMPTY) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the last allowed wait cycle; an empty FIFO or soft reset wins.
  assign tmo = (state == WAIT_TILL_EMPTY) && !e && !sr &&
               (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 1'b0;
    else     tmo_q <= tmo;
  end

  assign timeout_err = tmo_q;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DECODE_ADDRESS;
    else     state <= next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_sel <= '0;
    end else if (state == DECODE_ADDRESS && pkt_valid && din_ok) begin
      dest_sel <= din;
    end
  end

  always_comb begin
    next = state;
    if (state != DECODE_ADDRESS && sr) begin
      next = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (!din_ok)    next = DROP_PACKET;
            else if (e_din) next = LOAD_FIRST_DATA;
            else            next = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: next = LOAD_DATA;
        LOAD_DATA: begin
          if (f)               next = FIFO_FULL_STATE;
          else if (!pkt_valid) next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!f) next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        next = DECODE_ADDRESS;
          else if (low_pkt_valid) next = LOAD_PARITY;
          else                    next = LOAD_DATA;
        end
        LOAD_PARITY: next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          next = f ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (e)        next = LOAD_FIRST_DATA;
          else if (tmo) next = DROP_PACKET;
        end
        DROP_PACKET: begin
          if (!pkt_valid) next = DECODE_ADDRESS;
        end
        default: next = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_addr = (state == DECODE_ADDRESS);
  assign lfd_state   = (state == LOAD_FIRST_DATA);
  assign ld_state    = (state == LOAD_DATA);
  assign laf_state   = (state == LOAD_AFTER_FULL);
  assign full_state  = (state == FIFO_FULL_STATE);
  assign rst_int_reg = (state == CHECK_PARITY_ERROR);
  assign drop_pkt    = (state == DROP_PACKET);
  assign wr_en_req   = ld_state || laf_state ||
                       (state == LOAD_PARITY);
  assign busy        = !(detect_addr || ld_state || drop_pkt);

endmodule
